// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8-bit UART transmitter among four byte requesters.
// Issues SND until the transmitter reports busy, then waits for ready before the next grant.
module uart_tx_arbiter #(
   parameter logic [7:0]  NOP         = 8'd0,
   parameter logic [7:0]  SND         = 8'd255,
   parameter logic [7:0]  RDY         = 8'd0,
   parameter logic [7:0]  BSY         = 8'd255,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  REQ_VALID,
   input  logic [31:0] REQ_DATA,
   input  logic [3:0]  REQ_LOCK,
   output logic [3:0]  REQ_READY,
   output logic [7:0]  TX_CONTROL,
   output logic [7:0]  TX_DATA,
   input  logic [7:0]  TX_STATUS,
   output logic [1:0]  GRANT,
   output logic        BUSY,
   output logic        ERR
);
   localparam int unsigned CW = $clog2(ACK_TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE} state_t;

   state_t        state_q;
   logic [1:0]    ptr_q;
   logic [1:0]    owner_q;
   logic [1:0]    grant_q;
   logic          lock_q;
   logic          err_q;
   logic [CW-1:0] cnt_q;
   logic [7:0]    ctl_q;
   logic [7:0]    data_q;

   logic          tx_rdy;
   logic          tx_bsy;
   logic          hold;
   logic          found;
   logic          xfer;
   logic [1:0]    win;
   logic [1:0]    idx;
   logic [3:0]    ready;

   // Case equality keeps an unknown status (transmitter has no reset) from looking ready.
   always_comb begin
      tx_rdy = (TX_STATUS === RDY);
      tx_bsy = (TX_STATUS === BSY);
      hold   = lock_q && REQ_LOCK[owner_q];
      win    = owner_q;
      idx    = '0;
      found  = 1'b0;
      if (hold) begin
         found = REQ_VALID[owner_q];
      end else begin
         for (int unsigned k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && REQ_VALID[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
      end
      ready = '0;
      if (!RST && state_q == IDLE && tx_rdy && found) ready[win] = 1'b1;
      xfer = |ready;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= 2'd3;
         owner_q <= '0;
         grant_q <= '0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         ctl_q   <= NOP;
         data_q  <= '0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (lock_q && !REQ_LOCK[owner_q]) lock_q <= 1'b0;
               if (xfer) begin
                  data_q  <= REQ_DATA[{win, 3'b000} +: 8];
                  ctl_q   <= SND;
                  grant_q <= win;
                  ptr_q   <= win;
                  owner_q <= win;
                  lock_q  <= REQ_LOCK[win];
                  cnt_q   <= '0;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q <= cnt_q + CW'(1);
               if (tx_bsy) begin
                  ctl_q   <= NOP;
                  state_q <= ACTIVE;
               end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                  ctl_q   <= NOP;
                  err_q   <= 1'b1;
                  lock_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            ACTIVE: begin
               if (tx_rdy) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign REQ_READY  = ready;
   assign TX_CONTROL = ctl_q;
   assign TX_DATA    = data_q;
   assign GRANT      = grant_q;
   assign BUSY       = (state_q != IDLE);
   assign ERR        = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART transmitter and line decoder.
module tb_uart_tx_arbiter;
   localparam int BIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_lock = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic [7:0]  tx_control;
   logic [7:0]  tx_data;
   logic [7:0]  tx_status;
   logic [1:0]  grant;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic       m_busy = 1'b0;
   logic [9:0] m_shift = '1;
   int         m_bit = 0;
   int         m_tick = 0;
   logic       stuck = 1'b0;
   logic       line;

   logic [1:0] xfer_log[$];
   logic [7:0] rx_q[$];
   int frame_err = 0;
   int ready_viol = 0;
   int snd_bsy_viol = 0;
   int snd_rises = 0;
   int err_pulses = 0;
   logic [7:0] prev_ctl = 8'h00;

   uart_tx_arbiter #(
      .NOP(8'd0), .SND(8'd255), .RDY(8'd0), .BSY(8'd255), .ACK_TIMEOUT(16)
   ) dut (
      .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
      .REQ_LOCK(req_lock), .REQ_READY(req_ready), .TX_CONTROL(tx_control),
      .TX_DATA(tx_data), .TX_STATUS(tx_status), .GRANT(grant), .BUSY(busy), .ERR(err)
   );

   always #5 clk = ~clk;

   // Transmitter: no reset, samples SND when idle, busy for 10 bit times.
   assign tx_status = m_busy ? 8'hFF : 8'h00;
   assign line      = m_busy ? m_shift[m_bit] : 1'b1;

   always @(posedge clk) begin
      if (!m_busy) begin
         if (tx_control == 8'hFF && !stuck) begin
            m_busy  <= 1'b1;
            m_shift <= {1'b1, tx_data, 1'b0};
            m_bit   <= 0;
            m_tick  <= 0;
         end
      end else if (m_tick == BIT - 1) begin
         m_tick <= 0;
         if (m_bit == 9) m_busy <= 1'b0;
         else m_bit <= m_bit + 1;
      end else begin
         m_tick <= m_tick + 1;
      end
   end

   initial begin
      logic [7:0] b;
      logic ok;
      forever begin
         @(negedge line);
         repeat (BIT / 2) @(posedge clk);
         ok = (line == 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(posedge clk);
            b[i] = line;
         end
         repeat (BIT) @(posedge clk);
         if (line !== 1'b1) ok = 1'b0;
         if (!ok) frame_err++;
         rx_q.push_back(b);
      end
   end

   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (req_valid[i] && req_ready[i]) xfer_log.push_back(2'(i));

   always @(negedge clk) begin
      if ($countones(req_ready) > 1 || (req_ready != 4'b0 && busy)) ready_viol++;
      if (tx_control == 8'hFF && prev_ctl != 8'hFF) begin
         snd_rises++;
         if (tx_status == 8'hFF) snd_bsy_viol++;
      end
      prev_ctl = tx_control;
      if (err) err_pulses++;
   end

   task automatic wait_xfer(input int n, input int budget, output bit ok);
      int c = 0;
      while (xfer_log.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (xfer_log.size() >= n);
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int c = 0;
      ok = 1'b0;
      while (c < budget && !ok) begin
         @(negedge clk);
         c++;
         ok = (!busy && tx_status == 8'h00);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (tx_control !== 8'h00) begin errors++; $display("FAIL reset_ctl: got %0h expected 0", tx_control); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", tx_data); end
      checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      rst = 1'b0;
   endtask

   task automatic test_single_byte();
      bit ok;
      int n = 0;
      xfer_log.delete(); rx_q.delete();
      req_data = 32'h00A5_0000; req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
      wait_xfer(1, 10, ok);
      req_valid = '0;
      checks++; if (!ok) begin errors++; $display("FAIL single_xfer: got no transfer expected one"); end
      checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", tx_data); end
      checks++; if (grant !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", grant); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b expected 1", busy); end
      while (tx_control == 8'hFF && n < 20) begin n++; @(negedge clk); end
      checks++; if (n != 2) begin errors++; $display("FAIL single_snd_len: got %0d expected 2", n); end
      n = 0;
      while (tx_status != 8'h00 && n < 100) begin n++; @(negedge clk); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_rdy: got %0b expected 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %0b expected 0", busy); end
      checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL single_rx_count: got %0d expected 1", rx_q.size()); end
      checks++; if ((rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'hA5) begin errors++; $display("FAIL single_rx_byte: got %0h expected a5", rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
      checks++; if (frame_err != 0) begin errors++; $display("FAIL single_frame: got %0d framing errors expected 0", frame_err); end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [1:0] exp_g[5];
      logic [7:0] exp_b[5];
      exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      xfer_log.delete(); rx_q.delete();
      req_data = 32'h1312_1110; req_valid = 4'hF;
      wait_xfer(5, 400, ok);
      req_valid = '0;
      checks++; if (!ok) begin errors++; $display("FAIL rr_xfers: got %0d transfers expected 5", xfer_log.size()); end
      wait_idle(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_idle: got busy expected idle"); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ((i < xfer_log.size() ? xfer_log[i] : 2'bxx) !== exp_g[i]) begin
            errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, i < xfer_log.size() ? xfer_log[i] : 2'bxx, exp_g[i]);
         end
         checks++;
         if ((i < rx_q.size() ? rx_q[i] : 8'hxx) !== exp_b[i]) begin
            errors++; $display("FAIL rr_byte%0d: got %0h expected %0h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_b[i]);
         end
      end
      checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL rr_rx_count: got %0d expected 5", rx_q.size()); end
   endtask

   task automatic test_lock();
      bit ok;
      bit done = 1'b0;
      int c = 0;
      logic [1:0] exp_g[4];
      logic [7:0] exp_b[4];
      exp_g = '{2'd1, 2'd1, 2'd1, 2'd0};
      exp_b = '{8'h21, 8'h22, 8'h23, 8'h30};
      xfer_log.delete(); rx_q.delete();
      req_data = 32'h0000_2130; req_valid = 4'b0011; req_lock = 4'b0010;
      while (!done && c < 500) begin
         @(negedge clk);
         c++;
         if (xfer_log.size() == 1) req_data[15:8] = 8'h22;
         if (xfer_log.size() == 2) req_data[15:8] = 8'h23;
         if (xfer_log.size() == 3) begin req_valid[1] = 1'b0; req_lock[1] = 1'b0; end
         if (xfer_log.size() == 4) begin req_valid = '0; done = 1'b1; end
      end
      checks++; if (!done) begin errors++; $display("FAIL lock_xfers: got %0d transfers expected 4", xfer_log.size()); end
      wait_idle(100, ok);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ((i < xfer_log.size() ? xfer_log[i] : 2'bxx) !== exp_g[i]) begin
            errors++; $display("FAIL lock_grant%0d: got %0d expected %0d", i, i < xfer_log.size() ? xfer_log[i] : 2'bxx, exp_g[i]);
         end
         checks++;
         if ((i < rx_q.size() ? rx_q[i] : 8'hxx) !== exp_b[i]) begin
            errors++; $display("FAIL lock_byte%0d: got %0h expected %0h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_b[i]);
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int n = 0;
      int e0 = err_pulses;
      xfer_log.delete(); rx_q.delete();
      stuck = 1'b1;
      req_data = 32'h5A00_0000; req_valid = 4'b1000;
      wait_xfer(1, 20, ok);
      req_valid = '0;
      checks++; if (!ok) begin errors++; $display("FAIL to_xfer: got no transfer expected one"); end
      while (tx_control == 8'hFF && n < 40) begin n++; @(negedge clk); end
      checks++; if (n != 16) begin errors++; $display("FAIL to_snd_len: got %0d expected 16", n); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %0b expected 1", err); end
      checks++; if (tx_control !== 8'h00) begin errors++; $display("FAIL to_ctl: got %0h expected 0", tx_control); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy %0b expected 0", busy); end
      stuck = 1'b0;
      req_data = 32'h0000_6600; req_valid = 4'b0010;
      @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %0b expected 0", err); end
      wait_xfer(2, 20, ok);
      req_valid = '0;
      checks++; if (grant !== 2'd1) begin errors++; $display("FAIL to_next_grant: got %0d expected 1", grant); end
      wait_idle(100, ok);
      checks++; if ((rx_q.size() == 1 ? rx_q[0] : 8'hxx) !== 8'h66) begin errors++; $display("FAIL to_next_byte: got %0d bytes first %0h expected one byte 66", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
      checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL to_err_count: got %0d expected 1", err_pulses - e0); end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int c = 0;
      int early = 0;
      int f0 = frame_err;
      xfer_log.delete(); rx_q.delete();
      req_data = 32'h0000_00C3; req_valid = 4'b0001;
      wait_xfer(1, 20, ok);
      req_valid = '0;
      while (!(m_busy && m_bit == 4) && c < 100) begin c++; @(negedge clk); end
      checks++; if (!(m_busy && m_bit == 4)) begin errors++; $display("FAIL rmf_bit4: got bit %0d expected 4", m_bit); end
      rst = 1'b1; req_data = 32'h7700_0000; req_valid = 4'b1000;
      @(negedge clk);
      checks++; if (tx_control !== 8'h00) begin errors++; $display("FAIL rmf_ctl: got %0h expected 0", tx_control); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmf_data: got %0h expected 0", tx_data); end
      checks++; if (grant !== 2'd0) begin errors++; $display("FAIL rmf_grant: got %0d expected 0", grant); end
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rmf_busy_err: got %0b%0b expected 00", busy, err); end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rmf_ready: got %b expected 0000", req_ready); end
      c = 0;
      while (tx_status == 8'hFF && c < 100) begin
         @(negedge clk);
         c++;
         if (tx_status == 8'hFF && req_ready != 4'b0) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL rmf_early_ready: got %0d cycles expected 0", early); end
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rmf_ready_at_rdy: got %b expected 1000", req_ready); end
      wait_xfer(2, 20, ok);
      req_valid = '0;
      wait_idle(100, ok);
      checks++; if ((rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'hC3) begin errors++; $display("FAIL rmf_frame: got %0h expected c3", rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
      checks++; if ((rx_q.size() > 1 ? rx_q[1] : 8'hxx) !== 8'h77) begin errors++; $display("FAIL rmf_next: got %0h expected 77", rx_q.size() > 1 ? rx_q[1] : 8'hxx); end
      checks++; if (frame_err != f0) begin errors++; $display("FAIL rmf_framing: got %0d new errors expected 0", frame_err - f0); end
   endtask

   task automatic test_withdrawn();
      bit ok;
      int c = 0;
      int s0 = snd_rises;
      xfer_log.delete(); rx_q.delete();
      req_data = 32'h003C_0000; req_valid = 4'b0100;
      wait_xfer(1, 20, ok);
      req_valid = '0;
      while (tx_status != 8'hFF && c < 10) begin c++; @(negedge clk); end
      repeat (3) @(negedge clk);
      req_data[31:24] = 8'hEE; req_valid = 4'b1000;
      #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL wd_ready: got %b expected 0000", req_ready); end
      @(negedge clk);
      req_valid = '0;
      wait_idle(100, ok);
      repeat (3) @(negedge clk);
      checks++; if (xfer_log.size() != 1) begin errors++; $display("FAIL wd_xfers: got %0d expected 1", xfer_log.size()); end
      checks++; if (snd_rises - s0 != 1) begin errors++; $display("FAIL wd_snd: got %0d expected 1", snd_rises - s0); end
      checks++; if ((rx_q.size() == 1 ? rx_q[0] : 8'hxx) !== 8'h3C) begin errors++; $display("FAIL wd_rx: got %0d bytes first %0h expected one byte 3c", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
   endtask

   task automatic test_invariants();
      checks++; if (ready_viol != 0) begin errors++; $display("FAIL inv_ready: got %0d violations expected 0", ready_viol); end
      checks++; if (snd_bsy_viol != 0) begin errors++; $display("FAIL inv_snd_bsy: got %0d violations expected 0", snd_bsy_viol); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_round_robin();
      test_lock();
      test_timeout();
      test_reset_mid_frame();
      test_withdrawn();
      test_invariants();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
